price_window_sequencer: RTL and testbench

Controller for the per-tick indicator pipeline. It accepts a price stream with a valid/ready handshake and owns the WINDOW-deep circular price buffer. For each accepted price it issues one strobe, with new/oldest price and fill count, to up to N_IND indicator engines (RSI, SMA, …). It then collects their `done` pulses, with a timeout, and reports one round-complete event before accepting the next price.

---
 rtl/ta_pkg.sv | 26 ++
 rtl/price_window_buf.sv | 48 ++++
 rtl/price_window_sequencer.sv | 146 ++++++++++++++
 tb/tb_price_window_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ta_pkg.sv
// ta_pkg: definitions shared by the price window sequencer and the indicator
// engines.
//   seq_state_t  - sequencer FSM state encoding
//   CNT_W        - width of window pointer and fill-count fields
//   DEF_WINDOW   - default window depth
//   DEF_DW       - default price width
//   sat_inc()    - increment that saturates at a limit
package ta_pkg;

  localparam int CNT_W      = 5;
  localparam int DEF_WINDOW = 14;
  localparam int DEF_DW     = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_REPORT = 2'd3
  } seq_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                               input logic [CNT_W-1:0] lim);
    return (val >= lim) ? lim : val + 1'b1;
  endfunction

endpackage

// File: rtl/price_window_buf.sv
// price_window_buf: WINDOW-deep circular price buffer.
//   clk, rst   - clock, async active-high reset (clears pointer and count only)
//   flush      - clear pointer and count
//   we         - write wr_data at wr_ptr, advance pointer, bump count
//   wr_data    - price to store
//   rd_oldest  - slot at wr_ptr; once full this is the price about to be evicted
//   count      - number of valid entries, saturating at WINDOW
module price_window_buf
  import ta_pkg::*;
#(
  parameter int WINDOW = DEF_WINDOW,
  parameter int DW     = DEF_DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             we,
  input  logic [DW-1:0]    wr_data,
  output logic [DW-1:0]    rd_oldest,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(WINDOW);

  logic [DW-1:0] mem [WINDOW];
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (we) begin
      wr_ptr <= (wr_ptr == AW'(WINDOW - 1)) ? '0 : wr_ptr + 1'b1;
      count  <= sat_inc(count, CNT_W'(WINDOW));
    end
  end

  // Contents are don't-care after reset; count says which slots are valid.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= wr_data;
  end

  assign rd_oldest = mem[wr_ptr];

endmodule

// File: rtl/price_window_sequencer.sv
// price_window_sequencer: accepts one price per round, strobes the indicator
// engines with new/oldest price and fill count, collects their done pulses
// (with timeout) and reports a round-complete event.
//   clk, rst          - clock, async active-high reset
//   in_valid/in_price - offered price; in_ready accepts it
//   flush             - clear window (IDLE only, wins over in_valid)
//   cfg_enable        - per-engine enable, sampled at ISSUE
//   ind_strobe        - one-cycle strobe with ind_price/ind_oldest/ind_count/ind_full
//   ind_done          - per-engine completion pulses (honoured in WAIT only)
//   round_valid       - one-cycle pulse with round_done_mask / round_timeout
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | ready for a price; flush clears the window
// ST_ISSUE  | strobe engines, write price into window, load pend/timer
// ST_WAIT   | collect done pulses until all enabled engines or timeout
// ST_REPORT | round_valid pulse, then back to IDLE
module price_window_sequencer
  import ta_pkg::*;
#(
  parameter int WINDOW  = DEF_WINDOW,
  parameter int DW      = DEF_DW,
  parameter int N_IND   = 3,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_price,
  output logic             in_ready,
  input  logic             flush,
  input  logic [N_IND-1:0] cfg_enable,
  output logic             ind_strobe,
  output logic [DW-1:0]    ind_price,
  output logic [DW-1:0]    ind_oldest,
  output logic [4:0]       ind_count,
  output logic             ind_full,
  input  logic [N_IND-1:0] ind_done,
  output logic             round_valid,
  output logic [N_IND-1:0] round_done_mask,
  output logic             round_timeout
);

  localparam int TW = $clog2(TIMEOUT);
  // Down-counter: WAIT cycle k (from 0) sees TIMEOUT-1-k; zero marks the last one.
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

  seq_state_t       state;
  logic             ready_q;
  logic [N_IND-1:0] pend;
  logic [N_IND-1:0] got;
  logic [N_IND-1:0] got_nxt;
  logic [TW-1:0]    tmr;
  logic             accept;
  logic             all_done;
  logic             buf_flush;
  logic             buf_we;
  logic             win_full;
  logic [DW-1:0]    buf_oldest;
  logic [CNT_W-1:0] buf_count;
  logic [CNT_W-1:0] count_post;

  // ready_q is registered so in_ready stays low through reset and rises one
  // clock after release; flush masks it combinationally.
  assign in_ready   = ready_q & ~flush;
  assign accept     = (state == ST_IDLE) & in_valid & in_ready;
  assign buf_flush  = (state == ST_IDLE) & flush;
  assign buf_we     = (state == ST_ISSUE);
  assign win_full   = (buf_count == CNT_W'(WINDOW));
  assign count_post = sat_inc(buf_count, CNT_W'(WINDOW));
  assign got_nxt    = got | (ind_done & pend);
  assign all_done   = (got_nxt == pend);

  price_window_buf #(
    .WINDOW (WINDOW),
    .DW     (DW)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (buf_flush),
    .we        (buf_we),
    .wr_data   (ind_price),
    .rd_oldest (buf_oldest),
    .count     (buf_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      ready_q         <= 1'b0;
      pend            <= '0;
      got             <= '0;
      tmr             <= '0;
      ind_strobe      <= 1'b0;
      ind_price       <= '0;
      ind_oldest      <= '0;
      ind_count       <= '0;
      ind_full        <= 1'b0;
      round_valid     <= 1'b0;
      round_done_mask <= '0;
      round_timeout   <= 1'b0;
    end else begin
      ind_strobe    <= 1'b0;
      round_valid   <= 1'b0;
      round_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state      <= ST_ISSUE;
            ready_q    <= 1'b0;
            ind_strobe <= 1'b1;
            ind_price  <= in_price;
            ind_oldest <= win_full ? buf_oldest : '0;
            ind_count  <= count_post;
            ind_full   <= (count_post == CNT_W'(WINDOW));
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_ISSUE: begin
          pend  <= cfg_enable;
          got   <= '0;
          tmr   <= TMR_LOAD;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          got <= got_nxt;
          if (all_done || tmr == '0) begin
            state           <= ST_REPORT;
            round_valid     <= 1'b1;
            round_timeout   <= ~all_done;
            round_done_mask <= got_nxt | ~pend;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        ST_REPORT: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_price_window_sequencer.sv
module tb_price_window_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_price;
  logic        in_ready;
  logic        flush;
  logic [2:0]  cfg_enable;
  logic        ind_strobe;
  logic [15:0] ind_price;
  logic [15:0] ind_oldest;
  logic [4:0]  ind_count;
  logic        ind_full;
  logic [2:0]  ind_done;
  logic        round_valid;
  logic [2:0]  round_done_mask;
  logic        round_timeout;

  int checks = 0;
  int errors = 0;

  // observations from the last run_round
  logic        r_acc, r_strobe, r_full, r_to;
  logic [15:0] r_price, r_oldest;
  logic [4:0]  r_count;
  logic [2:0]  r_mask;
  int          r_rv;

  always #5 clk = ~clk;

  price_window_sequencer #(
    .WINDOW (14),
    .DW     (16),
    .N_IND  (3),
    .TIMEOUT(64)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_price       (in_price),
    .in_ready       (in_ready),
    .flush          (flush),
    .cfg_enable     (cfg_enable),
    .ind_strobe     (ind_strobe),
    .ind_price      (ind_price),
    .ind_oldest     (ind_oldest),
    .ind_count      (ind_count),
    .ind_full       (ind_full),
    .ind_done       (ind_done),
    .round_valid    (round_valid),
    .round_done_mask(round_done_mask),
    .round_timeout  (round_timeout)
  );

  // Called at a negedge in IDLE (cycle T). Offers one price, pulses done_vec
  // during cycle T+done_at (0 = never), holds flush during cycles
  // T+ff..T+ft, records the strobe contents (T+1) and the round report,
  // r_rv being the cycle offset of round_valid. Returns at the negedge of
  // the cycle after the report.
  task automatic run_round(input logic [15:0] price, input logic [2:0] done_vec,
                           input int done_at, input int ff, input int ft);
    int t;
    r_acc    = in_ready;
    in_valid = 1'b1;
    in_price = price;
    @(negedge clk);
    t        = 1;
    in_valid = 1'b0;
    r_strobe = ind_strobe;
    r_price  = ind_price;
    r_oldest = ind_oldest;
    r_count  = ind_count;
    r_full   = ind_full;
    r_rv     = -1;
    r_mask   = 'x;
    r_to     = 1'bx;
    while (t < 200 && r_rv < 0) begin
      ind_done = (t == done_at) ? done_vec : 3'b000;
      flush    = (t >= ff && t <= ft);
      @(negedge clk);
      t++;
      if (round_valid) begin
        r_rv   = t;
        r_mask = round_done_mask;
        r_to   = round_timeout;
      end
    end
    ind_done = 3'b000;
    flush    = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_price   = '0;
    flush      = 1'b0;
    cfg_enable = 3'b111;
    ind_done   = 3'b000;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++;
    if ({ind_strobe, round_valid, round_timeout, ind_full} !== 4'b0000) begin
      errors++; $display("FAIL reset_pulses: got %b expected 0000", {ind_strobe, round_valid, round_timeout, ind_full});
    end
    checks++;
    if ({ind_price, ind_oldest, ind_count, round_done_mask} !== 40'd0) begin
      errors++; $display("FAIL reset_data: price %0d oldest %0d count %0d mask %b expected all 0",
                         ind_price, ind_oldest, ind_count, round_done_mask);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_release_ready: got %b expected 0", in_ready); end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_rise: got %b expected 1", in_ready); end
  endtask

  // Back-to-back rounds filling the window; each starts the cycle in_ready returns.
  task automatic test_fill;
    cfg_enable = 3'b111;
    for (int i = 0; i < 14; i++) begin
      run_round(16'(100 + i), 3'b111, 2, 0, -1);
      checks++; if (r_acc !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d]: got %b expected 1", i, r_acc); end
      checks++; if (r_strobe !== 1'b1) begin errors++; $display("FAIL fill_strobe[%0d]: got %b expected 1", i, r_strobe); end
      checks++; if (r_price !== 16'(100 + i)) begin errors++; $display("FAIL fill_price[%0d]: got %0d expected %0d", i, r_price, 100 + i); end
      checks++; if (r_oldest !== 16'd0) begin errors++; $display("FAIL fill_oldest[%0d]: got %0d expected 0", i, r_oldest); end
      checks++; if (r_count !== 5'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, r_count, i + 1); end
      checks++; if (r_full !== (i == 13)) begin errors++; $display("FAIL fill_full[%0d]: got %b expected %b", i, r_full, i == 13); end
      checks++; if (r_rv != 3) begin errors++; $display("FAIL fill_round_at[%0d]: got T+%0d expected T+3", i, r_rv); end
      checks++; if (r_mask !== 3'b111) begin errors++; $display("FAIL fill_mask[%0d]: got %b expected 111", i, r_mask); end
      checks++; if (r_to !== 1'b0) begin errors++; $display("FAIL fill_timeout[%0d]: got %b expected 0", i, r_to); end
    end
  endtask

  task automatic test_wrap;
    run_round(16'd114, 3'b111, 2, 0, -1);
    checks++; if (r_oldest !== 16'd100) begin errors++; $display("FAIL wrap15_oldest: got %0d expected 100", r_oldest); end
    checks++; if (r_count !== 5'd14) begin errors++; $display("FAIL wrap15_count: got %0d expected 14", r_count); end
    checks++; if (r_full !== 1'b1) begin errors++; $display("FAIL wrap15_full: got %b expected 1", r_full); end
    run_round(16'd115, 3'b111, 2, 0, -1);
    checks++; if (r_oldest !== 16'd101) begin errors++; $display("FAIL wrap16_oldest: got %0d expected 101", r_oldest); end
    checks++; if (r_count !== 5'd14) begin errors++; $display("FAIL wrap16_count: got %0d expected 14", r_count); end
    checks++; if (r_price !== 16'd115) begin errors++; $display("FAIL wrap16_price: got %0d expected 115", r_price); end
  endtask

  task automatic test_timeout;
    cfg_enable = 3'b111;
    run_round(16'd500, 3'b011, 2, 0, -1);
    checks++; if (r_rv != 66) begin errors++; $display("FAIL timeout_round_at: got T+%0d expected T+66", r_rv); end
    checks++; if (r_to !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b expected 1", r_to); end
    checks++; if (r_mask !== 3'b011) begin errors++; $display("FAIL timeout_mask: got %b expected 011", r_mask); end
  endtask

  // Done pulses during ISSUE are stale and must not count.
  task automatic test_stale_done;
    cfg_enable = 3'b111;
    run_round(16'd501, 3'b111, 1, 0, -1);
    checks++; if (r_rv != 66) begin errors++; $display("FAIL stale_round_at: got T+%0d expected T+66", r_rv); end
    checks++; if (r_to !== 1'b1) begin errors++; $display("FAIL stale_timeout: got %b expected 1", r_to); end
    checks++; if (r_mask !== 3'b000) begin errors++; $display("FAIL stale_mask: got %b expected 000", r_mask); end
  endtask

  task automatic test_disabled;
    cfg_enable = 3'b000;
    run_round(16'd600, 3'b000, 0, 0, -1);
    checks++; if (r_rv != 3) begin errors++; $display("FAIL empty_round_at: got T+%0d expected T+3", r_rv); end
    checks++; if (r_mask !== 3'b111) begin errors++; $display("FAIL empty_mask: got %b expected 111", r_mask); end
    checks++; if (r_to !== 1'b0) begin errors++; $display("FAIL empty_timeout: got %b expected 0", r_to); end
    // engine 1 disabled and silent; enabled engines 0 and 2 report
    cfg_enable = 3'b101;
    run_round(16'd601, 3'b101, 2, 0, -1);
    checks++; if (r_rv != 3) begin errors++; $display("FAIL partial_round_at: got T+%0d expected T+3", r_rv); end
    checks++; if (r_mask !== 3'b111) begin errors++; $display("FAIL partial_mask: got %b expected 111", r_mask); end
    checks++; if (r_to !== 1'b0) begin errors++; $display("FAIL partial_timeout: got %b expected 0", r_to); end
    cfg_enable = 3'b111;
  endtask

  task automatic test_flush;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_price = 16'd999;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", in_ready); end
    @(negedge clk);
    checks++; if (ind_strobe !== 1'b0) begin errors++; $display("FAIL flush_no_accept: got strobe %b expected 0", ind_strobe); end
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    run_round(16'd200, 3'b111, 2, 0, -1);
    checks++; if (r_count !== 5'd1) begin errors++; $display("FAIL flush_count: got %0d expected 1", r_count); end
    checks++; if (r_oldest !== 16'd0) begin errors++; $display("FAIL flush_oldest: got %0d expected 0", r_oldest); end
    checks++; if (r_price !== 16'd200) begin errors++; $display("FAIL flush_price: got %0d expected 200", r_price); end
    // flush held during WAIT, dropped before the report
    run_round(16'd201, 3'b111, 4, 2, 3);
    checks++; if (r_rv != 5) begin errors++; $display("FAIL wait_flush_round_at: got T+%0d expected T+5", r_rv); end
    checks++; if (r_count !== 5'd2) begin errors++; $display("FAIL wait_flush_count2: got %0d expected 2", r_count); end
    run_round(16'd202, 3'b111, 2, 0, -1);
    checks++; if (r_count !== 5'd3) begin errors++; $display("FAIL wait_flush_count3: got %0d expected 3", r_count); end
  endtask

  task automatic test_reset_in_wait;
    logic saw_rv;
    saw_rv   = 1'b0;
    in_valid = 1'b1;
    in_price = 16'd300;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst      = 1'b1;
    ind_done = 3'b111;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstwait_ready: got %b expected 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (round_valid !== 1'b0 || in_ready !== 1'b0) saw_rv = 1'b1;
    end
    checks++; if (saw_rv !== 1'b0) begin errors++; $display("FAIL rstwait_quiet: got activity %b expected 0", saw_rv); end
    ind_done = 3'b000;
    rst      = 1'b0;
    @(negedge clk);
    checks++; if (round_valid !== 1'b0) begin errors++; $display("FAIL rstwait_no_round: got %b expected 0", round_valid); end
    run_round(16'd301, 3'b111, 2, 0, -1);
    checks++; if (r_acc !== 1'b1) begin errors++; $display("FAIL rstwait_accept: got %b expected 1", r_acc); end
    checks++; if (r_count !== 5'd1) begin errors++; $display("FAIL rstwait_count: got %0d expected 1", r_count); end
    checks++; if (r_oldest !== 16'd0) begin errors++; $display("FAIL rstwait_oldest: got %0d expected 0", r_oldest); end
    checks++; if (r_rv != 3) begin errors++; $display("FAIL rstwait_round_at: got T+%0d expected T+3", r_rv); end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_wrap;
    test_timeout;
    test_stale_done;
    test_disabled;
    test_flush;
    test_reset_in_wait;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
